// File: rtl/router_pkg.sv
// Shared router definitions: scheduler state encoding, arbiter slot directions,
// default timing limits and a small priority helper.
package router_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_FILL = 2'd2
    } sched_state_e;

    localparam int unsigned DIR_PE = 0;
    localparam int unsigned DIR_W  = 1;
    localparam int unsigned DIR_S  = 2;
    localparam int unsigned DIR_N  = 3;

    localparam int unsigned DEF_FILL_TIMEOUT = 7;
    localparam int unsigned DEF_STARVE_LIMIT = 12;

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!found && v[i]) begin
                idx   = 2'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/out_port_scheduler_if.sv
// Request/grant bundle between the input interfaces, one output-port scheduler
// and its output controller.
interface out_port_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic               polarity;
    logic               empty;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] clear;
    logic [1:0]         grant_idx;
    logic               busy;
    logic               err;
    logic [NUM_REQ-1:0] starve;

    modport master (
        input  polarity, empty, req,
        output grant, clear, grant_idx, busy, err, starve
    );

    modport slave (
        output polarity, empty, req,
        input  grant, clear, grant_idx, busy, err, starve
    );
endinterface

// File: rtl/out_port_scheduler_rr_pick.sv
// Combinational rotate-priority picker: first requester at or after ptr wins.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [1:0]         win_idx,
    output logic               valid
);
    logic [1:0] cand;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        valid   = 1'b0;
        cand    = '0;
        // 2-bit add gives the mod-4 wrap of the search order for free
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ptr + 2'(k);
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                win_idx      = cand;
                win_oh[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/out_port_scheduler.sv
// Output-port scheduler: round-robin grant of a single-entry output buffer, phase
// aligned, with fill confirmation. OUT_SCHED_STARVE_MON_EN adds starvation override.
module out_port_scheduler
    import router_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter logic        ARB_PHASE    = 1'b0,
    parameter int unsigned FILL_TIMEOUT = DEF_FILL_TIMEOUT,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input logic                  clk,
    input logic                  reset,
    out_port_scheduler_if.master bus
);

    if (NUM_REQ != 4 || FILL_TIMEOUT < 1 || FILL_TIMEOUT > 15 || STARVE_LIMIT > 15) begin : g_param_check
        $error("out_port_scheduler: unsupported parameter set");
    end

    sched_state_e       state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         idx_q, idx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [3:0]         fill_q, fill_d;

    logic [NUM_REQ-1:0] rr_oh;
    logic [1:0]         rr_idx;
    logic               rr_valid;
    logic [NUM_REQ-1:0] win_oh;
    logic [1:0]         win_idx;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (rr_oh),
        .win_idx (rr_idx),
        .valid   (rr_valid)
    );

`ifdef OUT_SCHED_STARVE_MON_EN
    logic [3:0]         wait_q [NUM_REQ];
    logic [3:0]         wait_d [NUM_REQ];
    logic [NUM_REQ-1:0] starve_flag;
    logic [NUM_REQ-1:0] starve_req;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = '0;
            if (bus.req[i] && !grant_q[i]) begin
                wait_d[i] = (wait_q[i] == 4'hF) ? wait_q[i] : wait_q[i] + 4'd1;
            end
            starve_flag[i] = (32'(wait_q[i]) >= STARVE_LIMIT);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!reset) begin
                wait_q[i] <= '0;
            end else begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    // Starving requesters pre-empt round-robin, lowest index first
    assign starve_req = starve_flag & bus.req;
    assign win_idx    = (|starve_req) ? lowest_set(starve_req) : rr_idx;
    assign win_oh     = (|starve_req) ? (NUM_REQ'(1) << lowest_set(starve_req)) : rr_oh;
    assign bus.starve = starve_flag;
`else
    assign win_idx    = rr_idx;
    assign win_oh     = rr_oh;
    assign bus.starve = '0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = '0;
        err_d   = err_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: begin
                if (bus.empty && rr_valid && (bus.polarity == ARB_PHASE)) begin
                    idx_d   = win_idx;
                    grant_d = win_oh;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                ptr_d   = idx_q + 2'd1;
                fill_d  = '0;
                state_d = WAIT_FILL;
            end
            WAIT_FILL: begin
                if (!bus.empty) begin
                    state_d = IDLE;
                end else begin
                    fill_d = fill_q + 4'd1;
                    if (32'(fill_d) == FILL_TIMEOUT) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            fill_q  <= fill_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.clear     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_out_port_scheduler.sv
// Self-checking bench for out_port_scheduler: directed scenarios plus randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_out_port_scheduler;

    localparam int unsigned FILL_TO    = 7;
    localparam int unsigned STARVE_LIM = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic pol = 1'b0;

    out_port_scheduler_if #(.NUM_REQ(4)) bus ();

    out_port_scheduler #(
        .NUM_REQ      (4),
        .ARB_PHASE    (1'b0),
        .FILL_TIMEOUT (FILL_TO),
        .STARVE_LIMIT (STARVE_LIM)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: transaction view of the port
    int         m_ptr;
    int         m_win;
    bit         m_granting;
    int         m_fill;       // -1 when no fill is outstanding
    int         m_wait [4];
    logic [3:0] e_grant;
    logic [1:0] e_idx;
    logic       e_busy;
    logic       e_err;
    logic [3:0] e_starve;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic p, input logic emp, input logic [3:0] rq);
        logic [3:0] hungry;
        logic [3:0] new_starve;
        int         w;
        bit         found;
        if (!r) begin
            m_ptr = 0; m_win = 0; m_granting = 0; m_fill = -1;
            for (int i = 0; i < 4; i++) m_wait[i] = 0;
            e_grant = '0; e_idx = '0; e_busy = 1'b0; e_err = 1'b0; e_starve = '0;
            return;
        end
        hungry     = e_starve & rq;
        new_starve = '0;
`ifdef OUT_SCHED_STARVE_MON_EN
        for (int i = 0; i < 4; i++) begin
            if (rq[i] && !e_grant[i]) m_wait[i] = (m_wait[i] < 15) ? m_wait[i] + 1 : 15;
            else m_wait[i] = 0;
            new_starve[i] = (m_wait[i] >= int'(STARVE_LIM));
        end
`endif
        if (m_granting) begin
            m_ptr      = (m_win + 1) % 4;
            m_granting = 0;
            m_fill     = 0;
            e_grant    = '0;
            e_busy     = 1'b1;
        end else if (m_fill >= 0) begin
            e_grant = '0;
            if (!emp) begin
                m_fill = -1;
                e_busy = 1'b0;
            end else begin
                m_fill++;
                if (m_fill == int'(FILL_TO)) begin
                    e_err  = 1'b1;
                    m_fill = -1;
                    e_busy = 1'b0;
                end
            end
        end else if (emp && rq != 4'b0 && p == 1'b0) begin
            w = 0;
            found = 0;
            if (hungry != 4'b0) begin
                for (int i = 0; i < 4; i++) if (!found && hungry[i]) begin w = i; found = 1; end
            end else begin
                for (int k = 0; k < 4; k++) if (!found && rq[(m_ptr + k) % 4]) begin w = (m_ptr + k) % 4; found = 1; end
            end
            m_win      = w;
            m_granting = 1;
            e_grant    = 4'(1 << w);
            e_idx      = 2'(w);
            e_busy     = 1'b1;
        end else begin
            e_grant = '0;
            e_busy  = 1'b0;
        end
        e_starve = new_starve;
    endtask

    // Drive one cycle's inputs, step the model, then sample on the falling edge
    task automatic cycle(input logic r, input logic emp, input logic [3:0] rq);
        rst_n        = r;
        bus.empty    = emp;
        bus.req      = rq;
        bus.polarity = pol;
        model_step(r, pol, emp, rq);
        @(negedge clk);
        pol = ~pol;
        chk("grant", bus.grant, e_grant);
        chk("clear", bus.clear, e_grant);
        chk("grant_idx", bus.grant_idx, e_idx);
        chk("busy", bus.busy, e_busy);
        chk("err", bus.err, e_err);
        chk("starve", bus.starve, e_starve);
    endtask

    // Buffer stand-in: it loads during the cycle after a grant
    function automatic logic emp_rule();
        return !(bus.busy && bus.grant == 4'b0);
    endfunction

    task automatic run_until_grant(input logic [3:0] rq, input bit hold_empty,
                                   output logic [3:0] g, output logic [1:0] gi);
        bit seen = 0;
        g  = '0;
        gi = '0;
        for (int t = 0; t < 40 && !seen; t++) begin
            cycle(1'b1, hold_empty ? 1'b1 : emp_rule(), rq);
            if (bus.grant != 4'b0) begin
                seen = 1;
                g    = bus.grant;
                gi   = bus.grant_idx;
            end
        end
        chk("grant_seen", 32'(seen), 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 30 && bus.busy; t++) cycle(1'b1, emp_rule(), 4'b0);
        chk("drain_idle", bus.busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] g;
        logic [1:0] gi;
        logic [3:0] seq [5];
        logic [3:0] rq;
        int         n;

        rst_n = 1'b0; bus.empty = 1'b1; bus.req = '0; bus.polarity = 1'b0;
        @(negedge clk);

        // Reset held with all requesting
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'b1111);
        chk("rst_grant", bus.grant, 4'b0);
        chk("rst_idx", bus.grant_idx, 2'd0);

        // Fairness under full load
        n = 0;
        for (int t = 0; t < 60 && n < 5; t++) begin
            cycle(1'b1, emp_rule(), 4'b1111);
            if (bus.grant != 4'b0) begin
                seq[n] = bus.grant;
                n++;
            end
        end
        chk("fair_count", 32'(n), 32'd5);
`ifndef OUT_SCHED_STARVE_MON_EN
        chk("fair_0", seq[0], 4'b0001);
        chk("fair_1", seq[1], 4'b0010);
        chk("fair_2", seq[2], 4'b0100);
        chk("fair_3", seq[3], 4'b1000);
        chk("fair_4", seq[4], 4'b0001);
`endif
        drain();

        // Phase alignment: request rises on the off phase
        if (pol == 1'b0) cycle(1'b1, 1'b1, 4'b0);
        cycle(1'b1, 1'b1, 4'b0100);
        chk("phase_early", bus.grant, 4'b0);
        cycle(1'b1, 1'b1, 4'b0100);
        chk("phase_grant", bus.grant, 4'b0100);
        drain();

        // Pointer wrap 3 -> 0 -> 1
        run_until_grant(4'b1001, 0, g, gi);
        chk("wrap_first", gi, 2'd3);
        run_until_grant(4'b0001, 0, g, gi);
        chk("wrap_second", gi, 2'd0);
        drain();
        run_until_grant(4'b0011, 0, g, gi);
        chk("wrap_ptr1", g, 4'b0010);
        drain();

        // Fill timeout
        run_until_grant(4'b0001, 1, g, gi);
        n = 0;
        for (int t = 0; t < 20; t++) begin
            cycle(1'b1, 1'b1, 4'b0);
            if (!bus.busy) break;
            n++;
        end
        chk("fill_wait_len", 32'(n), 32'(FILL_TO));
        chk("fill_err", bus.err, 1'b1);
        run_until_grant(4'b0100, 1, g, gi);
        chk("after_err_grant", g, 4'b0100);
        chk("err_sticky", bus.err, 1'b1);
        drain();

        // Reset during the grant cycle
        run_until_grant(4'b0010, 0, g, gi);
        cycle(1'b0, 1'b1, 4'b0010);
        chk("midrst_grant", bus.grant, 4'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_err", bus.err, 1'b0);
        run_until_grant(4'b1111, 0, g, gi);
        chk("midrst_ptr0", g, 4'b0001);
        drain();

`ifdef OUT_SCHED_STARVE_MON_EN
        cycle(1'b0, 1'b1, 4'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'b0010);
        chk("starve_flag", bus.starve, 4'b0010);
        run_until_grant(4'b0011, 1, g, gi);
        chk("starve_override", g, 4'b0010);
        drain();
`endif

        // Randomized traffic with hold-until-granted requesters
        rq = '0;
        for (int t = 0; t < 500; t++) begin
            logic r;
            logic emp;
            r = ($urandom_range(0, 63) != 0);
            if (bus.busy && bus.grant == 4'b0) emp = ($urandom_range(0, 4) == 0);
            else emp = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) rq = rq | 4'($urandom_range(0, 15));
            cycle(r, emp, rq);
            rq = rq & ~bus.grant;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
